sram_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's two memory ports: data port A (addr/control/write data) and

---
 rtl/sram_mem_responder.sv | 121 ++++++++++++
 tb/tb_sram_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_responder.sv
// Serialises the CPU data port (A) and fetch port (B) onto one
// single-port SRAM with programmable wait states, stalling the CPU.
module sram_mem_responder #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       Aaddr,
  input  logic [1:0]        memControl,
  input  logic [15:0]       writeData,
  input  logic [15:0]       Baddr,
  output logic [15:0]       AmemRead,
  output logic [15:0]       BmemRead,
  output logic              memStall,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [15:0]       sramWdata,
  input  logic [15:0]       sramRdata,
  output logic              sramCe,
  output logic              sramOe,
  output logic              sramWe
);

  typedef enum logic [1:0] {
    SAMPLE,
    A_ACC,
    B_ACC,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_STATES);

  state_t      state;
  state_t      stateNxt;
  logic [3:0]  waitCnt;
  logic [3:0]  waitCntNxt;
  logic [1:0]  opReg;
  logic [15:0] aAddrReg;
  logic [15:0] wDataReg;
  logic [15:0] bAddrReg;
  logic [15:0] addrWord;
  logic        lastCyc;
  logic        opRd;
  logic        opWr;
  logic        newOpAcc;

  assign lastCyc  = (waitCnt == LAST);
  assign opRd     = (opReg == 2'b01);
  assign opWr     = (opReg == 2'b10);
  assign newOpAcc = (memControl == 2'b01) ||
                    (memControl == 2'b10);
  assign sramAddr = ADDR_W'(addrWord);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SAMPLE;
      waitCnt  <= '0;
      opReg    <= '0;
      aAddrReg <= '0;
      wDataReg <= '0;
      bAddrReg <= '0;
      AmemRead <= '0;
      BmemRead <= '0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitCntNxt;
      if (state == SAMPLE) begin
        opReg    <= memControl;
        aAddrReg <= Aaddr;
        wDataReg <= writeData;
        bAddrReg <= Baddr;
      end
      if (state == A_ACC && opRd && lastCyc)
        AmemRead <= sramRdata;
      if (state == B_ACC && lastCyc)
        BmemRead <= sramRdata;
    end
  end

  always_comb begin
    stateNxt   = state;
    waitCntNxt = '0;
    addrWord   = '0;
    sramWdata  = '0;
    sramCe     = 1'b0;
    sramOe     = 1'b0;
    sramWe     = 1'b0;
    memStall   = 1'b1;
    unique case (state)
      SAMPLE: begin
        stateNxt = newOpAcc ? A_ACC : B_ACC;
      end
      A_ACC: begin
        sramCe   = 1'b1;
        addrWord = aAddrReg;
        sramOe   = opRd;
        if (opWr) begin
          sramWe    = 1'b1;
          sramWdata = wDataReg;
        end
        if (lastCyc) stateNxt = B_ACC;
        else waitCntNxt = waitCnt + 4'd1;
      end
      B_ACC: begin
        sramCe   = 1'b1;
        sramOe   = 1'b1;
        addrWord = bAddrReg;
        if (lastCyc) stateNxt = DONE;
        else waitCntNxt = waitCnt + 4'd1;
      end
      DONE: begin
        memStall = 1'b0;
        stateNxt = SAMPLE;
      end
      default: stateNxt = SAMPLE;
    endcase
    // Hold the CPU for as long as reset is asserted.
    if (rst) memStall = 1'b1;
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: W=1 instance on an SRAM model,
// plus W=0 and W=3 instances on an address-derived read pattern.
module tb_sram_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic [15:0] Aaddr;
  logic [1:0]  memControl;
  logic [15:0] writeData;
  logic [15:0] Baddr;

  logic [15:0] aRd, bRd, wdat, rdat;
  logic [17:0] addr;
  logic        stall, ce, oe, we;

  logic [15:0] aRd0, bRd0, wdat0, addr0;
  logic        stall0, ce0, oe0, we0;
  logic [15:0] aRd3, bRd3, wdat3, addr3;
  logic        stall3, ce3, oe3, we3;

  logic [15:0] mem [0:65535];

  int errors = 0;
  int checks = 0;
  int weCnt  = 0;
  int bothOn = 0;
  logic [17:0] weAddr = '0;

  always #5 clk = ~clk;

  sram_mem_responder #(.WAIT_STATES(1), .ADDR_W(18)) uMain (
    .clk(clk), .rst(rst), .Aaddr(Aaddr), .memControl(memControl),
    .writeData(writeData), .Baddr(Baddr), .AmemRead(aRd),
    .BmemRead(bRd), .memStall(stall), .sramAddr(addr),
    .sramWdata(wdat), .sramRdata(rdat), .sramCe(ce), .sramOe(oe),
    .sramWe(we)
  );

  sram_mem_responder #(.WAIT_STATES(0), .ADDR_W(16)) u0 (
    .clk(clk), .rst(rst), .Aaddr(Aaddr), .memControl(memControl),
    .writeData(writeData), .Baddr(Baddr), .AmemRead(aRd0),
    .BmemRead(bRd0), .memStall(stall0), .sramAddr(addr0),
    .sramWdata(wdat0), .sramRdata(~addr0), .sramCe(ce0),
    .sramOe(oe0), .sramWe(we0)
  );

  sram_mem_responder #(.WAIT_STATES(3), .ADDR_W(16)) u3 (
    .clk(clk), .rst(rst), .Aaddr(Aaddr), .memControl(memControl),
    .writeData(writeData), .Baddr(Baddr), .AmemRead(aRd3),
    .BmemRead(bRd3), .memStall(stall3), .sramAddr(addr3),
    .sramWdata(wdat3), .sramRdata(~addr3), .sramCe(ce3),
    .sramOe(oe3), .sramWe(we3)
  );

  assign rdat = mem[addr[15:0]];

  always @(posedge clk) begin
    if (preload) begin
      mem[16'h0010] <= 16'h1234;
      mem[16'h0011] <= 16'h5555;
      mem[16'h0200] <= 16'hBEEF;
      mem[16'h0300] <= 16'h7777;
      mem[16'h0042] <= 16'h0000;
      mem[16'h0050] <= 16'h0000;
    end else if (ce && we) begin
      mem[addr[15:0]] <= wdat;
    end
  end

  always @(negedge clk) begin
    if (!rst && we) begin
      weCnt  <= weCnt + 1;
      weAddr <= addr;
    end
    if (oe && we) bothOn <= bothOn + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic runMain(output int len);
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (stall && len < 40);
  endtask

  function automatic logic stallOf(input int sel);
    return (sel == 0) ? stall0 : stall3;
  endfunction

  task automatic period(input int sel, output int len);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stallOf(sel) && n < 40);
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (stallOf(sel) && len < 40);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] b;
    logic [15:0] expA;
    logic [15:0] expB;
    int          len;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int len;
    vecs[0] = '{2'b00, 16'h0000, 16'h0000, 16'h0010,
                16'h0000, 16'h1234, 4};
    vecs[1] = '{2'b01, 16'h0200, 16'h0000, 16'h0011,
                16'hBEEF, 16'h5555, 6};
    vecs[2] = '{2'b10, 16'h0042, 16'hA5A5, 16'h0042,
                16'hBEEF, 16'hA5A5, 6};
    vecs[3] = '{2'b11, 16'h0300, 16'hDEAD, 16'h0010,
                16'hBEEF, 16'h1234, 4};
    vecs[4] = '{2'b01, 16'h0042, 16'h0000, 16'h0300,
                16'hA5A5, 16'h7777, 6};
    vecs[5] = '{2'b00, 16'h0000, 16'h0000, 16'h0011,
                16'hA5A5, 16'h5555, 4};

    rst = 1'b1;
    preload = 1'b1;
    Aaddr = '0;
    memControl = '0;
    writeData = '0;
    Baddr = '0;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst memStall", 32'(stall), 32'd1);
    chk("rst sramCe", 32'(ce), 32'd0);
    chk("rst AmemRead", 32'(aRd), 32'd0);
    chk("rst BmemRead", 32'(bRd), 32'd0);
    chk("rst sramAddr", 32'(addr), 32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      memControl = vecs[i].op;
      Aaddr      = vecs[i].a;
      writeData  = vecs[i].wd;
      Baddr      = vecs[i].b;
      runMain(len);
      chk($sformatf("v%0d len", i), 32'(len), 32'(vecs[i].len));
      chk($sformatf("v%0d AmemRead", i), 32'(aRd), 32'(vecs[i].expA));
      chk($sformatf("v%0d BmemRead", i), 32'(bRd), 32'(vecs[i].expB));
    end
    chk("write cycles", 32'(weCnt), 32'd2);
    chk("write addr", 32'(weAddr), 32'h42);
    chk("reserved op mem", 32'(mem[16'h0300]), 32'h7777);

    // Reset lands in the second cycle of a write phase.
    memControl = 2'b10;
    Aaddr = 16'h0050;
    writeData = 16'h1111;
    Baddr = 16'h0050;
    repeat (3) @(negedge clk);
    chk("mid-write sramWe", 32'(we), 32'd1);
    rst = 1'b1;
    memControl = 2'b00;
    @(negedge clk);
    chk("rst sramWe", 32'(we), 32'd0);
    chk("rst sramOe", 32'(oe), 32'd0);
    chk("rst sramCe2", 32'(ce), 32'd0);
    chk("rst sramAddr2", 32'(addr), 32'd0);
    chk("rst sramWdata", 32'(wdat), 32'd0);
    chk("rst AmemRead2", 32'(aRd), 32'd0);
    chk("rst BmemRead2", 32'(bRd), 32'd0);
    chk("rst memStall2", 32'(stall), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    runMain(len);
    chk("post-rst len", 32'(len), 32'd4);
    chk("post-rst BmemRead", 32'(bRd), 32'h1111);
    chk("post-rst AmemRead", 32'(aRd), 32'd0);

    // Wait-state variants.
    rst = 1'b1;
    memControl = 2'b01;
    Aaddr = 16'h0123;
    Baddr = 16'h0456;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    period(0, len);
    chk("W0 load len", 32'(len), 32'd4);
    period(1, len);
    chk("W3 load len", 32'(len), 32'd10);
    chk("W3 AmemRead", 32'(aRd3), 32'hFEDC);
    chk("W3 BmemRead", 32'(bRd3), 32'hFBA9);
    chk("W0 AmemRead", 32'(aRd0), 32'hFEDC);
    chk("W0 BmemRead", 32'(bRd0), 32'hFBA9);
    memControl = 2'b00;
    period(0, len);
    chk("W0 fetch len", 32'(len), 32'd3);
    period(1, len);
    chk("W3 fetch len", 32'(len), 32'd6);

    // Inputs changed during B_ACC must not affect this step.
    repeat (2) @(negedge clk);
    chk("W3 in B_ACC", 32'(ce3), 32'd1);
    Baddr = 16'h0999;
    Aaddr = 16'h0777;
    memControl = 2'b01;
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (stall3 && len < 40);
    chk("W3 ignore len", 32'(len), 32'd4);
    chk("W3 ignore BmemRead", 32'(bRd3), 32'hFBA9);
    chk("W3 ignore AmemRead", 32'(aRd3), 32'hFEDC);
    chk("oe/we overlap", 32'(bothOn), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
